// File: rtl/ifmaps_fifo_window_reader.sv
// Read side of the 5-row ifmaps FIFO: pops one column per read and streams sliding 5x5 windows.
// Define IFMAP_ZERO_PAD_EN to add two zero columns on each edge of every strip.
module ifmaps_fifo_window_reader #(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter int unsigned IFMAP_WIDTH = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      fifo_empty,
  output logic                      fifo_read,
  input  logic [DATA_WIDTH-1:0]     fifo_row0_in,
  input  logic [DATA_WIDTH-1:0]     fifo_row1_in,
  input  logic [DATA_WIDTH-1:0]     fifo_row2_in,
  input  logic [DATA_WIDTH-1:0]     fifo_row3_in,
  input  logic [DATA_WIDTH-1:0]     fifo_row4_in,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [25*DATA_WIDTH-1:0]  win_data,
  output logic [CNT_W-1:0]          win_col_idx,
  output logic                      strip_done,
  output logic                      busy
);

  localparam int unsigned ColW = 5 * DATA_WIDTH;

`ifdef IFMAP_ZERO_PAD_EN
  localparam int unsigned PadCols = 2;
  localparam logic [CNT_W:0] PadLoEnd   = (CNT_W+1)'(PadCols);
  localparam logic [CNT_W:0] PadHiStart = (CNT_W+1)'(IFMAP_WIDTH + PadCols);
`else
  localparam int unsigned PadCols = 0;
`endif

  localparam int unsigned    TotalCols  = IFMAP_WIDTH + 2 * PadCols;
  localparam logic [CNT_W:0] TotalColsC = (CNT_W+1)'(TotalCols);
  localparam logic [CNT_W-1:0] WidthC   = CNT_W'(IFMAP_WIDTH);
  localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(TotalCols - 5);

  typedef enum logic [1:0] {StIdle, StFill, StStream, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cols_read_q, cols_read_d;
  logic [CNT_W:0]          col_in_q, col_in_d;
  logic [2:0]              fill_cnt_q, fill_cnt_d;
  logic                    rd_inflight_q, rd_inflight_d;
  logic [ColW-1:0]         pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4:0][ColW-1:0]    win_q, win_d;
  logic                    win_valid_q, win_valid_d;
  logic [CNT_W-1:0]        win_col_idx_q, win_col_idx_d;

  logic            active, slot_free, cols_left, next_is_pad, pad_in, new_col, xfer;
  logic [ColW-1:0] new_data;

`ifdef IFMAP_ZERO_PAD_EN
  assign next_is_pad = (col_in_q < PadLoEnd) || (col_in_q >= PadHiStart);
`else
  assign next_is_pad = 1'b0;
`endif

  assign active    = (state_q == StFill) || (state_q == StStream);
  assign slot_free = ((state_q == StFill) && (fill_cnt_q < 3'd5)) ||
                     ((state_q == StStream) && !pend_valid_q);
  assign cols_left = col_in_q < TotalColsC;
  // Pad columns cost no pop; they enter on the same terms as a captured FIFO column.
  assign fifo_read = active && !fifo_empty && (cols_read_q < WidthC) && !rd_inflight_q &&
                     slot_free && !next_is_pad && cols_left;
  assign pad_in    = active && !rd_inflight_q && slot_free && next_is_pad && cols_left;
  assign new_col   = rd_inflight_q || pad_in;
  assign new_data  = rd_inflight_q ?
                     {fifo_row4_in, fifo_row3_in, fifo_row2_in, fifo_row1_in, fifo_row0_in} : '0;
  assign xfer      = win_valid_q && win_ready;

  always_comb begin
    state_d       = state_q;
    cols_read_d   = cols_read_q;
    col_in_d      = col_in_q;
    fill_cnt_d    = fill_cnt_q;
    rd_inflight_d = fifo_read;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    win_d         = win_q;
    win_valid_d   = win_valid_q;
    win_col_idx_d = win_col_idx_q;

    if (rd_inflight_q) cols_read_d = cols_read_q + CNT_W'(1);
    if (new_col)       col_in_d    = col_in_q + (CNT_W+1)'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StFill;
          cols_read_d   = '0;
          col_in_d      = '0;
          fill_cnt_d    = '0;
          pend_valid_d  = 1'b0;
          win_col_idx_d = '0;
        end
      end
      StFill: begin
        if (new_col) begin
          win_d      = {new_data, win_q[4:1]};
          fill_cnt_d = fill_cnt_q + 3'd1;
          if (fill_cnt_q == 3'd4) begin
            state_d     = StStream;
            win_valid_d = 1'b1;
            fill_cnt_d  = '0;
          end
        end
      end
      StStream: begin
        if (xfer) begin
          if (win_col_idx_q == LastIdx) begin
            state_d     = StDone;
            win_valid_d = 1'b0;
          end else begin
            win_col_idx_d = win_col_idx_q + CNT_W'(1);
            if (pend_valid_q) begin
              win_d        = {pend_q, win_q[4:1]};
              pend_valid_d = 1'b0;
            end else begin
              // Column 4 is rewritten when the missing column lands.
              win_d       = {new_data, win_q[4:1]};
              win_valid_d = new_col;
            end
          end
        end else if (!win_valid_q) begin
          if (new_col) begin
            win_d[4]    = new_data;
            win_valid_d = 1'b1;
          end
        end else if (new_col) begin
          pend_d       = new_data;
          pend_valid_d = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cols_read_q   <= '0;
      col_in_q      <= '0;
      fill_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      win_q         <= '0;
      win_valid_q   <= 1'b0;
      win_col_idx_q <= '0;
    end else begin
      state_q       <= state_d;
      cols_read_q   <= cols_read_d;
      col_in_q      <= col_in_d;
      fill_cnt_q    <= fill_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      win_q         <= win_d;
      win_valid_q   <= win_valid_d;
      win_col_idx_q <= win_col_idx_d;
    end
  end

  assign win_valid   = win_valid_q;
  assign win_data    = win_q;
  assign win_col_idx = win_col_idx_q;
  assign strip_done  = (state_q == StDone);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ifmaps_fifo_window_reader.sv
// Scoreboard bench for ifmaps_fifo_window_reader: FIFO model, window reference model, monitor.
// Honours IFMAP_ZERO_PAD_EN for the expected window sequence.
module tb_ifmaps_fifo_window_reader;

  localparam int W  = 8;
  localparam int CW = 8;
`ifdef IFMAP_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int NWIN = PAD ? W : W - 4;

  typedef struct packed {
    logic [CW-1:0] idx;
    logic [24:0]   data;
  } exp_t;

  typedef logic [4:0] col_arr_t [W];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          fifo_empty = 1'b1;
  logic          fifo_read;
  logic [4:0]    rows = '0;
  logic          win_valid;
  logic          win_ready;
  logic [24:0]   win_data;
  logic [CW-1:0] win_col_idx;
  logic          strip_done;
  logic          busy;

  exp_t       exp_q [$];
  logic [4:0] fifo_q [$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, hs_cnt = 0, rd_cnt = 0, done_cnt = 0, last_hs_cyc = -10;

  ifmaps_fifo_window_reader #(
    .DATA_WIDTH (1),
    .IFMAP_WIDTH(W),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fifo_empty  (fifo_empty),
    .fifo_read   (fifo_read),
    .fifo_row0_in(rows[0]),
    .fifo_row1_in(rows[1]),
    .fifo_row2_in(rows[2]),
    .fifo_row3_in(rows[3]),
    .fifo_row4_in(rows[4]),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_data    (win_data),
    .win_col_idx (win_col_idx),
    .strip_done  (strip_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after a sampled pop.
  always @(posedge clk) begin
    if (fifo_read) begin
      if (fifo_q.size() > 0) rows <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor
  logic          prev_hold = 1'b0;
  logic [CW-1:0] prev_idx;
  logic [24:0]   prev_data;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk("hold_stable", 64'({win_valid, win_col_idx, win_data}),
            64'({1'b1, prev_idx, prev_data}));
      if (fifo_read) begin
        rd_cnt++;
        chk("read_while_empty", 64'(fifo_empty), 64'(0));
      end
      if (win_valid && win_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_window", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          chk("win_col_idx", 64'(win_col_idx), 64'(e.idx));
          chk("win_data", 64'(win_data), 64'(e.data));
        end
      end
      if (strip_done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
        chk("done_all_windows", 64'(exp_q.size()), 64'(0));
      end
      prev_hold = win_valid && !win_ready;
      prev_idx  = win_col_idx;
      prev_data = win_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_col(input logic [4:0] c);
    fifo_q.push_back(c);
    fifo_empty <= 1'b0;
  endtask

  // Reference: pad the column list if enabled, then every 5-wide slice is one window.
  task automatic expect_strip(input col_arr_t cols);
    logic [4:0] p [$];
    exp_t e;
    if (PAD) begin p.push_back(5'd0); p.push_back(5'd0); end
    for (int i = 0; i < W; i++) p.push_back(cols[i]);
    if (PAD) begin p.push_back(5'd0); p.push_back(5'd0); end
    for (int i = 0; i < NWIN; i++) begin
      e.idx = CW'(i);
      for (int k = 0; k < 5; k++) e.data[k*5 +: 5] = p[i+k];
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_cols(output col_arr_t cols);
    for (int i = 0; i < W; i++) cols[i] = 5'($urandom);
  endtask

  task automatic start_strip();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin step(); n++; end
    chk("strip_done_seen", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic run_feed(input col_arr_t cols, input int pre, input bit rnd);
    int nxt, d0, n;
    nxt = pre; d0 = done_cnt; n = 0;
    expect_strip(cols);
    for (int i = 0; i < pre; i++) push_col(cols[i]);
    win_ready = 1'b1;
    start_strip();
    while (done_cnt == d0 && n < 3000) begin
      if (nxt < W && (!rnd || $urandom_range(0, 1) == 1)) begin
        push_col(cols[nxt]);
        nxt++;
      end
      win_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      step();
      n++;
    end
    chk("strip_done_seen", 64'(done_cnt), 64'(d0 + 1));
    win_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_fifo_read"}, 64'(fifo_read), 64'(0));
    chk({tag, "_win_valid"}, 64'(win_valid), 64'(0));
    chk({tag, "_win_data"}, 64'(win_data), 64'(0));
    chk({tag, "_win_col_idx"}, 64'(win_col_idx), 64'(0));
    chk({tag, "_strip_done"}, 64'(strip_done), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    col_arr_t cols;
    int h0, r0, d0, n, nr, stall_n;

    // Reset for two edges, start asserted during the second.
    rst = 1'b1; start = 1'b0; win_ready = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Basic strip: column k is five copies of k[0].
    step();
    for (int k = 0; k < W; k++) cols[k] = {5{k[0]}};
    h0 = hs_cnt; r0 = rd_cnt; d0 = done_cnt;
    run_feed(cols, W, 1'b0);
    repeat (3) step();
    chk("basic_windows", 64'(hs_cnt - h0), 64'(NWIN));
    chk("basic_reads", 64'(rd_cnt - r0), 64'(W));
    chk("basic_done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("basic_busy_after", 64'(busy), 64'(0));

    // Backpressure on the first window.
    rand_cols(cols);
    expect_strip(cols);
    for (int i = 0; i < W; i++) push_col(cols[i]);
    win_ready = 1'b0;
    d0 = done_cnt;
    start_strip();
    n = 0;
    @(negedge clk);
    while (!win_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_first_window", 64'(win_valid), 64'(1));
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (fifo_read) nr++;
    end
    chk("bp_prefetch_reads", 64'(nr), 64'(1));
    @(posedge clk); #1;
    win_ready = 1'b1;
    wait_done(d0);
    repeat (2) step();

    // Empty stall: too few columns to complete the first window.
    stall_n = PAD ? 2 : 3;
    rand_cols(cols);
    expect_strip(cols);
    for (int i = 0; i < stall_n; i++) push_col(cols[i]);
    d0 = done_cnt;
    start_strip();
    repeat (20) step();
    @(negedge clk);
    chk("stall_win_valid", 64'(win_valid), 64'(0));
    chk("stall_fifo_read", 64'(fifo_read), 64'(0));
    chk("stall_busy", 64'(busy), 64'(1));
    step();
    for (int i = stall_n; i < W; i++) begin push_col(cols[i]); step(); end
    wait_done(d0);
    repeat (2) step();

    // Reset after the second handshake, then a clean strip.
    rand_cols(cols);
    expect_strip(cols);
    for (int i = 0; i < W; i++) push_col(cols[i]);
    win_ready = 1'b1;
    h0 = hs_cnt;
    start_strip();
    n = 0;
    while (hs_cnt < h0 + 2 && n < 200) begin step(); n++; end
    chk("mid_strip_handshakes", 64'(hs_cnt - h0), 64'(2));
    rst = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    fifo_empty <= 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    step();
    rand_cols(cols);
    run_feed(cols, W, 1'b0);
    repeat (2) step();

    // Randomised strips: random push timing and random backpressure.
    for (int s = 0; s < 6; s++) begin
      rand_cols(cols);
      h0 = hs_cnt; r0 = rd_cnt;
      run_feed(cols, $urandom_range(0, 3), 1'b1);
      repeat (2) step();
      chk("rand_windows", 64'(hs_cnt - h0), 64'(NWIN));
      chk("rand_reads", 64'(rd_cnt - r0), 64'(W));
    end

    repeat (5) step();
    chk("leftover_expected", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
